// File: rtl/circuito_exp3.sv
// circuito_exp3: steps a 4-bit counter through a 16x4 ROM, registers `chaves` once per
// address and compares the two. Define HEX_DEBUG_EN to drive the four 7-segment debug outputs.
module circuito_exp3 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FIM        = 4'hF
    } estado_t;

    estado_t    estado, proximo_estado;
    logic       zera_c, conta_c, zera_r, registra_r;
    logic       fim_c;
    logic [3:0] contagem, registro, memoria;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:    proximo_estado = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: proximo_estado = REGISTRA;
            REGISTRA:   proximo_estado = COMPARACAO;
            COMPARACAO: proximo_estado = fim_c ? FIM : PROXIMO;
            PROXIMO:    proximo_estado = REGISTRA;
            FIM:        proximo_estado = iniciar ? PREPARACAO : FIM;
            default:    proximo_estado = INICIAL;
        endcase
    end

    // Control outputs are registered from the next state, so each is high exactly while
    // the FSM sits in the state that owns it.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= INICIAL;
            zera_c     <= 1'b0;
            zera_r     <= 1'b0;
            registra_r <= 1'b0;
            conta_c    <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            estado     <= proximo_estado;
            zera_c     <= (proximo_estado == PREPARACAO);
            zera_r     <= (proximo_estado == PREPARACAO);
            registra_r <= (proximo_estado == REGISTRA);
            conta_c    <= (proximo_estado == PROXIMO);
            pronto     <= (proximo_estado == FIM);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= 4'h0;
            registro <= 4'h0;
        end else begin
            if (zera_c)       contagem <= 4'h0;
            else if (conta_c) contagem <= contagem + 4'h1;

            if (zera_r)          registro <= 4'h0;
            else if (registra_r) registro <= chaves;
        end
    end

    assign fim_c = (contagem == 4'hF);

    // NOTE: the ROM is a constant case table, so it has no storage to reset or initialise.
    always_comb begin
        memoria = 4'h0;
        case (contagem)
            4'h0: memoria = 4'h1;
            4'h1: memoria = 4'h2;
            4'h2: memoria = 4'h4;
            4'h3: memoria = 4'h8;
            4'h4: memoria = 4'h4;
            4'h5: memoria = 4'h2;
            4'h6: memoria = 4'h1;
            4'h7: memoria = 4'h1;
            4'h8: memoria = 4'h2;
            4'h9: memoria = 4'h2;
            4'hA: memoria = 4'h4;
            4'hB: memoria = 4'h4;
            4'hC: memoria = 4'h8;
            4'hD: memoria = 4'h8;
            4'hE: memoria = 4'h1;
            4'hF: memoria = 4'h4;
            default: memoria = 4'h0;
        endcase
    end

    assign db_igual   = (registro == memoria);
    assign db_iniciar = iniciar;

`ifdef HEX_DEBUG_EN
    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex7seg(input logic [3:0] valor);
        case (valor)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign db_contagem = hex7seg(contagem);
    assign db_memoria  = hex7seg(memoria);
    assign db_chaves   = hex7seg(registro);
    assign db_estado   = hex7seg(estado);
`else
    assign db_contagem = 7'b1111111;
    assign db_memoria  = 7'b1111111;
    assign db_chaves   = 7'b1111111;
    assign db_estado   = 7'b1111111;
`endif

endmodule

// File: tb/tb_circuito_exp3.sv
// Self-checking bench for circuito_exp3 against a cycle-indexed run model; checks the
// 7-segment outputs as decoded digits when HEX_DEBUG_EN is defined, all-off otherwise.
module tb_circuito_exp3;

    logic       clock = 1'b0;
    logic       reset, iniciar;
    logic [3:0] chaves;
    logic       pronto, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    circuito_exp3 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .db_igual(db_igual), .db_iniciar(db_iniciar),
        .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_chaves(db_chaves), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] ROM [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                                        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Run model: mode 0 = idle, 1 = running, 2 = done. In a run, cycle 0 is the clearing
    // cycle and cycle 1+3a+p is phase p (register/compare/advance) of address a.
    int         m_mode = 0;
    int         m_c    = 0;
    logic [3:0] m_cnt  = 4'h0;
    logic [3:0] m_rg   = 4'h0;

    function automatic logic [6:0] exp_seg(input logic [3:0] v);
`ifdef HEX_DEBUG_EN
        return SEG[v];
`else
        return 7'h7F;
`endif
    endfunction

    function automatic logic [3:0] m_state_code();
        if (m_mode == 0) return 4'h0;
        if (m_mode == 2) return 4'hF;
        if (m_c == 0)    return 4'h1;
        case ((m_c - 1) % 3)
            0:       return 4'h4;
            1:       return 4'h5;
            default: return 4'h6;
        endcase
    endfunction

    task automatic tick(input logic r, input logic ini, input logic [3:0] ch);
        reset = r; iniciar = ini; chaves = ch;
        @(posedge clock);
        if (r) begin
            m_mode = 0; m_cnt = 4'h0; m_rg = 4'h0;
        end else if (m_mode != 1) begin
            if (ini) begin m_mode = 1; m_c = 0; end
        end else begin
            if (m_c == 0) begin
                m_cnt = 4'h0; m_rg = 4'h0;
            end else if ((m_c - 1) % 3 == 0) m_rg = ch;
            else if ((m_c - 1) % 3 == 2)     m_cnt = m_cnt + 4'h1;
            m_c++;
            if (m_c == 48) m_mode = 2;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 4'h7);
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
        n_checks++; if (db_igual !== 1'b0) begin n_fail++; $display("FAIL reset_igual: got %b expected 0", db_igual); end
        n_checks++; if (db_memoria !== exp_seg(4'h1)) begin n_fail++; $display("FAIL reset_memoria: got %h expected %h", db_memoria, exp_seg(4'h1)); end
        n_checks++; if (db_chaves !== exp_seg(4'h0)) begin n_fail++; $display("FAIL reset_chaves: got %h expected %h", db_chaves, exp_seg(4'h0)); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 4'h3);
            n_checks++; if (db_estado !== exp_seg(4'h0)) begin n_fail++; $display("FAIL idle_estado: got %h expected %h", db_estado, exp_seg(4'h0)); end
            n_checks++; if (db_contagem !== exp_seg(4'h0)) begin n_fail++; $display("FAIL idle_contagem: got %h expected %h", db_contagem, exp_seg(4'h0)); end
            n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL idle_pronto: got %b expected 0", pronto); end
        end
    endtask

    task automatic test_start();
        logic [3:0] seq [5] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'h4};
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, (i == 0), 4'h4);
            n_checks++; if (db_estado !== exp_seg(seq[i])) begin n_fail++; $display("FAIL start_estado[%0d]: got %h expected %h", i, db_estado, exp_seg(seq[i])); end
            if (i == 1) begin
                n_checks++; if (db_igual !== 1'b0) begin n_fail++; $display("FAIL start_igual_reg0: got %b expected 0", db_igual); end
            end
            if (i == 2) begin
                n_checks++; if (db_chaves !== exp_seg(4'h4)) begin n_fail++; $display("FAIL start_chaves: got %h expected %h", db_chaves, exp_seg(4'h4)); end
                n_checks++; if (db_igual !== 1'b0) begin n_fail++; $display("FAIL start_igual_addr0: got %b expected 0", db_igual); end
            end
        end
    endtask

    task automatic test_match();
        int k = 0;
        while (!(m_state_code() == 4'h5 && m_cnt == 4'h2) && k < 20) begin
            tick(1'b0, 1'b0, 4'h4); k++;
        end
        n_checks++; if (k >= 20) begin n_fail++; $display("FAIL match_timeout: got %0d expected <20 cycles", k); end
        n_checks++; if (db_igual !== 1'b1) begin n_fail++; $display("FAIL match_igual_addr2: got %b expected 1", db_igual); end
        n_checks++; if (db_contagem !== exp_seg(4'h2)) begin n_fail++; $display("FAIL match_contagem: got %h expected %h", db_contagem, exp_seg(4'h2)); end
    endtask

    task automatic test_midrun_change();
        logic [3:0] ch  [5] = '{4'h2, 4'h2, 4'h9, 4'h9, 4'h9};
        logic       eq  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int k = 0;
        while (!(m_state_code() == 4'h6 && m_cnt == 4'h4) && k < 20) begin
            tick(1'b0, 1'b0, 4'h4); k++;
        end
        n_checks++; if (k >= 20) begin n_fail++; $display("FAIL midrun_timeout: got %0d expected <20 cycles", k); end
        // registra a5 (held 4), comparacao a5 (now 2), proximo a5, registra a6, comparacao a6 (9)
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, ch[i]);
            n_checks++; if (db_igual !== eq[i]) begin n_fail++; $display("FAIL midrun_igual[%0d]: got %b expected %b", i, db_igual, eq[i]); end
        end
        n_checks++; if (db_chaves !== exp_seg(4'h9)) begin n_fail++; $display("FAIL midrun_chaves: got %h expected %h", db_chaves, exp_seg(4'h9)); end
    endtask

    task automatic test_full_run(input logic hold_iniciar);
        logic [3:0] seq [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        int done_at = -1;
        tick(1'b1, 1'b0, 4'h0);
        tick(1'b0, 1'b1, 4'h1);
        for (int i = 1; i <= 60 && done_at < 0; i++) begin
            tick(1'b0, hold_iniciar, seq[((i - 1) / 6) % 6]);
            n_checks++; if (db_igual !== (m_rg == ROM[m_cnt])) begin n_fail++; $display("FAIL full_igual[%0d]: got %b expected %b", i, db_igual, (m_rg == ROM[m_cnt])); end
            if (pronto === 1'b1) done_at = i;
        end
        n_checks++; if (done_at != 48) begin n_fail++; $display("FAIL full_latency: got %0d expected 48 edges after preparacao", done_at); end
        n_checks++; if (db_estado !== exp_seg(4'hF)) begin n_fail++; $display("FAIL full_estado: got %h expected %h", db_estado, exp_seg(4'hF)); end
        n_checks++; if (db_contagem !== exp_seg(4'hF)) begin n_fail++; $display("FAIL full_contagem: got %h expected %h", db_contagem, exp_seg(4'hF)); end
    endtask

    task automatic test_restart();
        tick(1'b0, 1'b0, 4'h3);
        n_checks++; if (pronto !== 1'b1) begin n_fail++; $display("FAIL restart_hold_fim: got %b expected 1", pronto); end
        tick(1'b0, 1'b1, 4'h3);
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL restart_pronto: got %b expected 0", pronto); end
        n_checks++; if (db_estado !== exp_seg(4'h1)) begin n_fail++; $display("FAIL restart_estado: got %h expected %h", db_estado, exp_seg(4'h1)); end
        tick(1'b0, 1'b0, 4'h3);
        n_checks++; if (db_igual !== 1'b0) begin n_fail++; $display("FAIL restart_igual: got %b expected 0", db_igual); end
        n_checks++; if (db_contagem !== exp_seg(4'h0)) begin n_fail++; $display("FAIL restart_contagem: got %h expected %h", db_contagem, exp_seg(4'h0)); end
        n_checks++; if (db_chaves !== exp_seg(4'h0)) begin n_fail++; $display("FAIL restart_chaves: got %h expected %h", db_chaves, exp_seg(4'h0)); end
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 4'h1);
        tick(1'b1, 1'b1, 4'h1);
        n_checks++; if (db_estado !== exp_seg(4'h0)) begin n_fail++; $display("FAIL rstmid_estado: got %h expected %h", db_estado, exp_seg(4'h0)); end
        n_checks++; if (db_igual !== 1'b0) begin n_fail++; $display("FAIL rstmid_igual: got %b expected 0", db_igual); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 4'h1);
            n_checks++; if (pronto !== 1'b0 || db_igual !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got pronto=%b igual=%b expected 0/0", pronto, db_igual); end
        end
    endtask

    task automatic test_back_to_back();
        test_full_run(1'b1);
        tick(1'b0, 1'b1, 4'h5);
        n_checks++; if (pronto !== 1'b0) begin n_fail++; $display("FAIL b2b_leave_fim: got %b expected 0", pronto); end
        n_checks++; if (db_estado !== exp_seg(4'h1)) begin n_fail++; $display("FAIL b2b_estado: got %h expected %h", db_estado, exp_seg(4'h1)); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            n_checks++; if (pronto !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_pronto[%0d]: got %b expected %b", i, pronto, (m_mode == 2)); end
            n_checks++; if (db_igual !== (m_rg == ROM[m_cnt])) begin n_fail++; $display("FAIL rnd_igual[%0d]: got %b expected %b", i, db_igual, (m_rg == ROM[m_cnt])); end
            n_checks++; if (db_iniciar !== iniciar) begin n_fail++; $display("FAIL rnd_db_iniciar[%0d]: got %b expected %b", i, db_iniciar, iniciar); end
            n_checks++; if (db_estado !== exp_seg(m_state_code())) begin n_fail++; $display("FAIL rnd_estado[%0d]: got %h expected %h", i, db_estado, exp_seg(m_state_code())); end
            n_checks++; if (db_contagem !== exp_seg(m_cnt)) begin n_fail++; $display("FAIL rnd_contagem[%0d]: got %h expected %h", i, db_contagem, exp_seg(m_cnt)); end
            n_checks++; if (db_memoria !== exp_seg(ROM[m_cnt])) begin n_fail++; $display("FAIL rnd_memoria[%0d]: got %h expected %h", i, db_memoria, exp_seg(ROM[m_cnt])); end
            n_checks++; if (db_chaves !== exp_seg(m_rg)) begin n_fail++; $display("FAIL rnd_chaves[%0d]: got %h expected %h", i, db_chaves, exp_seg(m_rg)); end
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
        test_reset();
        test_start();
        test_match();
        test_midrun_change();
        test_full_run(1'b0);
        test_restart();
        test_reset_midrun();
        test_back_to_back();
        tick(1'b1, 1'b0, 4'h0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
